// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  // Iteration count of the radix-2 engine; one product/quotient bit per cycle.
  localparam int unsigned ITER = 32;

  // Operation encodings presented on op.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step.
// Ports: rem (partial remainder), dbit (next dividend bit), divisor
//        -> rem_next (updated remainder), qbit (quotient bit).
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;

  // rem < divisor on entry, so the shifted value is below 2*divisor and the
  // restored/subtracted remainder always fits in WIDTH bits.
  always_comb begin
    shifted  = {rem, dbit};
    qbit     = (shifted >= {1'b0, divisor});
    rem_next = qbit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Ports: clk, rst_n (sync, active low); start/op/data0/data1 launch an op;
//        mthi/mtlo/wdata write HI/LO; flush aborts; busy/done/div_zero status;
//        stall = start | busy; hi/lo architectural registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = muldiv_pkg::ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(ITER);

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             is_div, neg_res, neg_rem, dz;
  logic             load, step, commit;

  logic             signed_op;
  logic [WIDTH-1:0] mag0, mag1;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] rem_next;
  logic             qbit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign stall = start | busy;

  // Operand magnitudes; signed ops iterate on |x| and fix the sign at the end.
  always_comb begin
    signed_op = ~op[0];
    mag0      = (signed_op && data0[WIDTH-1]) ? -data0 : data0;
    mag1      = (signed_op && data1[WIDTH-1]) ? -data1 : data1;
  end

  // Shift-add multiply step: conditional add, then shift {sum, acc_lo} right.
  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc_hi),
    .dbit     (acc_lo[WIDTH-1]),
    .divisor  (opnd),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // Sign fix-up for the committed result.
  always_comb begin
    prod = {acc_hi, acc_lo};
    if (is_div) begin
      res_lo = neg_res ? -acc_lo : acc_lo;
      res_hi = neg_rem ? -acc_hi : acc_hi;
    end else begin
      if (neg_res) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and control decode; flush overrides everything but reset.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(ITER - 1)) state_next = FIX;
      end
      FIX: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      load       = 1'b0;
      step       = 1'b0;
      commit     = 1'b0;
    end
  end

  // Datapath, status outputs and HI/LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      busy     <= (state_next != IDLE);
      done     <= commit;
      div_zero <= commit & is_div & dz;

      if (load) begin
        cnt     <= '0;
        acc_hi  <= '0;
        acc_lo  <= mag0;
        opnd    <= mag1;
        is_div  <= op[1];
        neg_res <= signed_op & (data0[WIDTH-1] ^ data1[WIDTH-1]);
        neg_rem <= signed_op & data0[WIDTH-1];
        dz      <= (data1 == '0);
      end

      if (step) begin
        cnt <= cnt + CNT_W'(1);
        if (is_div) begin
          acc_hi <= rem_next;
          acc_lo <= {acc_lo[WIDTH-2:0], qbit};
        end else begin
          acc_hi <= sum[WIDTH:1];
          acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
        end
      end

      // Commit only happens in FIX, so it never collides with an IDLE mt write.
      if (commit) begin
        if (!(is_div && dz)) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else if (state == IDLE && !flush) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected HI/LO/div_zero.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] data0, data1, wdata;
  logic        busy, stall, done, div_zero;
  logic [31:0] hi, lo;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .data0(data0), .data1(data1), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .flush(flush), .busy(busy), .stall(stall),
    .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mhi = '0, mlo = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain SV arithmetic on the architectural definition.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [63:0] p;
    int          sa, sb;
    r.hi = mhi; r.lo = mlo; r.dz = 1'b0;
    sa = a; sb = b;
    case (o)
      OP_MULT:  begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      OP_DIV: begin
        if (b == 0) r.dz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r.lo = 32'h8000_0000; r.hi = 0; end
        else begin r.lo = 32'(sa / sb); r.hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) r.dz = 1'b1;
        else begin r.lo = a / b; r.hi = a % b; end
      end
    endcase
    return r;
  endfunction

  // Launch an op at posedge+1 and follow it to commit, checking timing and result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit mt_start, input bit mt_busy);
    exp_t e, g;
    int   n, nb;
    bit   seen;
    if (mt_start) mlo = 32'hAA;
    e = model(o, a, b);
    sbq.push_back(e);
    start = 1'b1; op = o; data0 = a; data1 = b; mtlo = mt_start; wdata = 32'hAA;
    #1 check_eq("stall_on_start", 64'(stall), 64'd1);
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); #1; n++;
      start = 1'b0; mtlo = 1'b0;
      if (n == 1 && mt_start) check_eq("lo_mt_with_start", 64'(lo), 64'h0AA);
      if (mt_busy && n == 5) begin mthi = 1'b1; wdata = 32'hDEAD_BEEF; end
      else mthi = 1'b0;
      if (busy) nb++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check_eq("done_timeout", 64'd0, 64'd1);
      void'(sbq.pop_front());
    end else begin
      check_eq("latency", 64'(n), 64'd34);
      check_eq("busy_cycles", 64'(nb), 64'd33);
      g = sbq.pop_front();
      check_eq("hi", 64'(hi), 64'(g.hi));
      check_eq("lo", 64'(lo), 64'(g.lo));
      check_eq("div_zero", 64'(div_zero), 64'(g.dz));
      mhi = g.hi; mlo = g.lo;
      @(posedge clk); #1;
      check_eq("done_pulse_end", 64'({done, div_zero}), 64'd0);
    end
  endtask

  initial begin
    bit          seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 0; mthi = 0; mtlo = 0; flush = 0;
    op = '0; data0 = '0; data1 = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hi_lo", {hi, lo}, 64'd0);
    check_eq("rst_flags", 64'({busy, done, div_zero, stall}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check_eq("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);

    // MT writes in IDLE, separately and together.
    mthi = 1; mtlo = 1; wdata = 32'h33;
    @(posedge clk); #1;
    check_eq("mt_both", {hi, lo}, {32'h33, 32'h33});
    mtlo = 0; wdata = 32'h11;
    @(posedge clk); #1;
    mthi = 0; mtlo = 1; wdata = 32'h22;
    @(posedge clk); #1;
    mtlo = 0;
    check_eq("mt_sep", {hi, lo}, {32'h11, 32'h22});
    mhi = 32'h11; mlo = 32'h22;

    run_op(OP_DIVU, 32'd100, 32'd0, 0, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(OP_DIVU, 32'd1000, 32'd7, 0, 1);

    // Flush mid-run: no commit, HI/LO preserved.
    start = 1; op = OP_MULTU; data0 = 32'd3; data1 = 32'd5;
    @(posedge clk); #1;
    start = 0;
    repeat (8) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check_eq("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check_eq("flush_no_done", 64'(seen), 64'd0);
    check_eq("flush_hilo", {hi, lo}, {mhi, mlo});

    // Flush with start in IDLE drops the start.
    start = 1; flush = 1;
    @(posedge clk); #1;
    start = 0; flush = 0;
    check_eq("flush_start_busy", 64'(busy), 64'd0);

    run_op(OP_MULTU, 32'd3, 32'd5, 0, 0);
    check_eq("multu_3x5", {hi, lo}, 64'd15);

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      if (i == 3) ra = -ra;
      run_op(ro, ra, rb, 0, 0);
    end

    run_op(OP_MULTU, 32'h1234, 32'h10, 1, 0);

    // Reset in the middle of RUN.
    start = 1; op = OP_MULT; data0 = 32'd9; data1 = 32'd9;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    check_eq("midrun_rst_hilo", {hi, lo}, 64'd0);
    check_eq("midrun_rst_busy", 64'(busy), 64'd0);
    rst_n = 1;
    mhi = '0; mlo = '0;
    @(posedge clk); #1;
    run_op(OP_MULTU, 32'd3, 32'd5, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
